// File: rtl/mem_access_pkg.sv
// Shared encodings and the access legality check for the load/store controller.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FIN,
        ST_ERR
    } state_e;

    // True when the access cannot be made: reserved size or not naturally aligned.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle of the load/store controller.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              lsigned;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, size, lsigned, addr, wdata,
        input  ready, done, err, rdata
    );

    modport slave (
        input  req, we, size, lsigned, addr, wdata,
        output ready, done, err, rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: sub-word store merge and load extract/extend.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_lsigned,
    output logic [31:0] o_new_word,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_new_word = i_word;
        case (i_size)
            SZ_BYTE: o_new_word[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_new_word[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            SZ_WORD: o_new_word = i_wdata;
            default: o_new_word = i_word;
        endcase
    end

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_word[{i_offset[1], 4'b0000} +: 16];
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_lsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_lsigned & w_half[15]}}, w_half};
            default: o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller: FSM plus registered RAM-side outputs; lane logic lives in mem_lane_align.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    mem_access_ctrl_if.slave  cpu,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_ram_write,
    output logic              o_ram_select
);

    state_e            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_lsigned;
    logic [1:0]        r_offset;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic              r_ram_write;
    logic              r_ram_select;

    logic [31:0] w_new_word;
    logic [31:0] w_load_data;

    mem_lane_align u_align (
        .i_word     (i_ram_rdata),
        .i_wdata    (r_wdata),
        .i_size     (r_size),
        .i_offset   (r_offset),
        .i_lsigned  (r_lsigned),
        .o_new_word (w_new_word),
        .o_rdata    (w_load_data)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_lsigned    <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= 32'h0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'h0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= 32'h0;
            r_ram_write  <= 1'b0;
            r_ram_select <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu.req) begin
                        r_we       <= cpu.we;
                        r_size     <= cpu.size;
                        r_lsigned  <= cpu.lsigned;
                        r_offset   <= cpu.addr[1:0];
                        r_wdata    <= cpu.wdata;
                        r_ram_addr <= cpu.addr[ADDR_W+1:2];
                        if (is_bad_access(cpu.size, cpu.addr[1:0])) begin
                            r_state <= ST_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!cpu.we || (cpu.size != SZ_WORD)) begin
                            // Loads and sub-word stores both need the current word first.
                            r_state      <= ST_RD;
                            r_ram_select <= 1'b1;
                        end else begin
                            r_state      <= ST_WR;
                            r_ram_select <= 1'b1;
                            r_ram_write  <= 1'b1;
                            r_ram_wdata  <= cpu.wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (r_we) begin
                        r_state     <= ST_WR;
                        r_ram_write <= 1'b1;
                        r_ram_wdata <= w_new_word;
                    end else begin
                        r_state      <= ST_FIN;
                        r_ram_select <= 1'b0;
                        r_done       <= 1'b1;
                        r_rdata      <= w_load_data;
                    end
                end
                ST_WR: begin
                    r_state      <= ST_FIN;
                    r_ram_select <= 1'b0;
                    r_ram_write  <= 1'b0;
                    r_done       <= 1'b1;
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_done       <= 1'b0;
                    r_err        <= 1'b0;
                    r_ram_write  <= 1'b0;
                    r_ram_select <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.ready    = (r_state == ST_IDLE);
    assign cpu.done     = r_done;
    assign cpu.err      = r_err;
    assign cpu.rdata    = r_rdata;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_ram_write  = r_ram_write;
    assign o_ram_select = r_ram_select;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-level memory model with a per-cycle expected-output queue.
module tb_mem_access_ctrl;
    localparam int unsigned ADDR_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) cpu ();

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_write;
    logic              ram_select;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .cpu          (cpu),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_ram_write  (ram_write),
        .o_ram_select (ram_select)
    );

    logic [31:0] ram [0:65535];
    initial for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    always @(posedge clk) if (ram_select && ram_write) ram[ram_addr] <= ram_wdata;
    assign ram_rdata = ram[ram_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One record per cycle describing what the outputs must be during that cycle.
    typedef struct {
        bit                ready;
        bit                done;
        bit                err;
        bit                sel;
        bit                wr;
        bit                rd_valid;
        logic [31:0]       rdata;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } cyc_t;

    cyc_t        q[$];
    logic [7:0]  mb [0:255];
    logic [31:0] m_rdata;

    function automatic cyc_t blank();
        cyc_t c;
        c.ready = 0; c.done = 0; c.err = 0; c.sel = 0; c.wr = 0; c.rd_valid = 0;
        c.rdata = 32'h0; c.addr = '0; c.wdata = 32'h0;
        return c;
    endfunction

    function automatic logic [31:0] model_word(input int wi);
        return {mb[4*wi+3], mb[4*wi+2], mb[4*wi+1], mb[4*wi]};
    endfunction

    function automatic void push_txn(input bit we, input logic [1:0] sz, input bit ls,
                                     input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        int a, off, n, wi;
        longint v;
        logic [7:0] tmp [0:3];
        cyc_t c;
        a   = int'(addr);
        off = a % 4;
        wi  = a / 4;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (off % n) != 0) begin
            c = blank(); c.done = 1; c.err = 1; q.push_back(c);
        end else if (!we) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mb[a+i]) << (8*i));
            if (ls && v[8*n-1]) v = v - (longint'(1) << (8*n));
            c = blank(); c.sel = 1; c.addr = ADDR_W'(wi); q.push_back(c);
            c = blank(); c.done = 1; c.rd_valid = 1; c.rdata = v[31:0]; q.push_back(c);
        end else begin
            for (int j = 0; j < 4; j++) tmp[j] = mb[4*wi+j];
            for (int i = 0; i < n; i++) tmp[off+i] = wd[8*i +: 8];
            if (n < 4) begin
                c = blank(); c.sel = 1; c.addr = ADDR_W'(wi); q.push_back(c);
            end
            c = blank(); c.sel = 1; c.wr = 1; c.addr = ADDR_W'(wi);
            c.wdata = {tmp[3], tmp[2], tmp[1], tmp[0]};
            q.push_back(c);
            c = blank(); c.done = 1; q.push_back(c);
        end
    endfunction

    // Reference model: retires the cycle just ended, then accepts a request if it was idle.
    initial begin
        bit   was_idle;
        cyc_t h;
        for (int i = 0; i < 256; i++) mb[i] = 8'h0;
        m_rdata = 32'h0;
        forever begin
            @(posedge clk);
            was_idle = (q.size() == 0);
            if (!was_idle) begin
                h = q.pop_front();
                if (h.wr) for (int i = 0; i < 4; i++) mb[4*int'(h.addr)+i] = h.wdata[8*i +: 8];
                if (h.rd_valid) m_rdata = h.rdata;
            end
            if (rst) begin
                q.delete();
                m_rdata = 32'h0;
            end else if (was_idle && cpu.req) begin
                push_txn(cpu.we, cpu.size, cpu.lsigned, cpu.addr, cpu.wdata);
            end
        end
    end

    // Compare process: every cycle after the first edge.
    initial begin
        cyc_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q.size() > 0) e = q[0];
            else begin
                e = blank(); e.ready = 1;
            end
            check("ready", 32'(cpu.ready), 32'(e.ready));
            check("done", 32'(cpu.done), 32'(e.done));
            check("err", 32'(cpu.err), 32'(e.err));
            check("rdata", cpu.rdata, e.rd_valid ? e.rdata : m_rdata);
            check("ram_select", 32'(ram_select), 32'(e.sel));
            check("ram_write", 32'(ram_write), 32'(e.wr));
            if (e.sel) check("ram_addr", 32'(ram_addr), 32'(e.addr));
            if (e.wr) check("ram_wdata", ram_wdata, e.wdata);
        end
    end

    task automatic do_req(input bit we, input logic [1:0] sz, input bit ls,
                          input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                          input int exp_lat, input bit exp_err,
                          input bit chk_rd, input logic [31:0] exp_rd);
        int n;
        bit seen_sel;
        cpu.req = 1; cpu.we = we; cpu.size = sz; cpu.lsigned = ls; cpu.addr = a; cpu.wdata = wd;
        seen_sel = 0;
        @(negedge clk);
        cpu.req = 0;
        n = 1;
        while (!cpu.done && n < 10) begin
            if (ram_select) seen_sel = 1;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("done_err", 32'(cpu.err), 32'(exp_err));
        if (exp_err) check("err_no_select", 32'(seen_sel | ram_select), 32'd0);
        if (chk_rd) check("load_value", cpu.rdata, exp_rd);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst = 1; cpu.req = 0; cpu.we = 0; cpu.size = 2'd0; cpu.lsigned = 0;
        cpu.addr = '0; cpu.wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cpu.ready), 32'd1);
        check("rst_done", 32'(cpu.done), 32'd0);
        check("rst_err", 32'(cpu.err), 32'd0);
        check("rst_rdata", cpu.rdata, 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_ram_wr_sel", {30'b0, ram_write, ram_select}, 32'h0);
        rst = 0;
        @(negedge clk);

        do_req(1, 2'd2, 0, 18'h0010, 32'hDEADBEEF, 2, 0, 0, 32'h0);
        do_req(0, 2'd2, 0, 18'h0010, 32'h0, 2, 0, 1, 32'hDEADBEEF);
        check("ram4_word_store", ram[4], 32'hDEADBEEF);
        check("model4_word_store", model_word(4), 32'hDEADBEEF);

        do_req(1, 2'd2, 0, 18'h0010, 32'h11223344, 2, 0, 0, 32'h0);
        do_req(1, 2'd0, 0, 18'h0011, 32'h000000AB, 3, 0, 0, 32'h0);
        check("ram4_byte_store", ram[4], 32'h1122AB44);
        check("model4_byte_store", model_word(4), 32'h1122AB44);

        do_req(1, 2'd2, 0, 18'h0010, 32'h8000F0FF, 2, 0, 0, 32'h0);
        do_req(0, 2'd0, 1, 18'h0010, 32'h0, 2, 0, 1, 32'hFFFFFFFF);
        do_req(0, 2'd1, 0, 18'h0012, 32'h0, 2, 0, 1, 32'h00008000);
        do_req(0, 2'd1, 1, 18'h0012, 32'h0, 2, 0, 1, 32'hFFFF8000);

        do_req(0, 2'd1, 0, 18'h0013, 32'h0, 1, 1, 0, 32'h0);
        do_req(1, 2'd2, 0, 18'h0012, 32'hCAFEF00D, 1, 1, 0, 32'h0);
        do_req(1, 2'd3, 0, 18'h0010, 32'h12345678, 1, 1, 0, 32'h0);
        check("ram4_after_errors", ram[4], 32'h8000F0FF);
        check("rdata_held_after_errors", cpu.rdata, 32'hFFFF8000);

        // req held high: accepts only when idle, one done per 3-cycle load.
        cpu.req = 1; cpu.we = 0; cpu.size = 2'd2; cpu.lsigned = 0; cpu.addr = 18'h0010;
        dn = 0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            if (cpu.done) dn++;
        end
        cpu.req = 0;
        check("held_req_dones", 32'(dn), 32'd4);
        @(negedge clk);

        // Reset during the WR cycle of a byte store.
        cpu.req = 1; cpu.we = 1; cpu.size = 2'd0; cpu.addr = 18'h0013; cpu.wdata = 32'h5A;
        @(negedge clk);
        cpu.req = 0;
        @(negedge clk);
        check("wr_phase_before_reset", 32'(ram_write), 32'd1);
        rst = 1;
        @(negedge clk);
        check("mid_rst_ready", 32'(cpu.ready), 32'd1);
        check("mid_rst_done", 32'(cpu.done), 32'd0);
        check("mid_rst_wr_sel", {30'b0, ram_write, ram_select}, 32'h0);
        check("mid_rst_rdata", cpu.rdata, 32'h0);
        check("ram4_write_completed", ram[4], 32'h5A00F0FF);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", 32'(cpu.ready), 32'd1);
        check("post_rst_no_done", 32'(cpu.done), 32'd0);

        for (int c = 0; c < 1500; c++) begin
            cpu.req     = ($urandom_range(0, 2) != 0);
            cpu.we      = $urandom_range(0, 1) != 0;
            cpu.size    = 2'($urandom_range(0, 3));
            cpu.lsigned = $urandom_range(0, 1) != 0;
            cpu.addr    = 18'($urandom_range(0, 63));
            cpu.wdata   = $urandom;
            rst         = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        rst = 0; cpu.req = 0;
        repeat (5) @(negedge clk);
        for (int w = 0; w < 16; w++) check("final_ram_word", ram[w], model_word(w));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store controller between the CPU memory stage and the 32-bit word-addressed data RAM. Accepts one byte-addressed load or store per request, handles byte/halfword/word sizes with little-endian lane placement, performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data with a one-cycle completion pulse. All RAM-side outputs are registered, so the RAM's level-sensitive write never sees a glitch.

## Interface
- ADDR_W, 16, RAM word-address width; CPU byte address is ADDR_W+2 bits
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  CPU request; sampled only when ready=1
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- lsigned  in  1  loads: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W+2  byte address; [1:0] = byte offset
- wdata  in  32  store data, right-justified
- ready  out  1  controller idle, will accept req
- done  out  1  one-cycle completion pulse
- err  out  1  with done: misaligned or reserved size, no RAM access made
- rdata  out  32  load result, valid while done=1, held until next done
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  32  to RAM data_in
- ram_rdata  in  32  from RAM data_out (combinational read)
- ram_write  out  1  to RAM write
- ram_select  out  1  to RAM select

## Operation
- States: IDLE, RD, WR, FIN, ERR. ready=1 only in IDLE.
- IDLE + req: latch we/size/lsigned/addr/wdata. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> ERR. Load -> RD. Word store -> WR. Byte/half store -> RD.
- RD: ram_select=1, ram_addr=addr[ADDR_W+1:2], ram_write=0; ram_rdata captured into word register at end of cycle. Next: load -> FIN; store -> WR.
- WR: ram_select=1, ram_write=1, ram_wdata = merged word (word store: wdata; sub-word: captured word with addressed lanes replaced). Next FIN.
- FIN: done=1, err=0; load: rdata = extracted lane(s) extended per lsigned. Stores leave rdata unchanged. -> IDLE.
- ERR: done=1, err=1, ram_select=0, rdata unchanged. -> IDLE.
- Lanes little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 2 occupies [31:16].
- req while ready=0 ignored; no queueing.
- ram_select=0 and ram_write=0 in IDLE, FIN, ERR.

## Timing
- Request accepted at edge T (IDLE, req=1). Load: RD in cycle T+1, done in T+2. Word store: WR in T+1, done in T+2. Sub-word store: RD T+1, WR T+2, done T+3. Error: done+err in T+1.
- Next request acceptable in the cycle after done (back-to-back throughput: 3 cycles/load).
- ram_* outputs are flop outputs; ram_addr and ram_wdata stable for the whole cycle ram_write=1.
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, ram_addr=0, ram_wdata=0, ram_write=0, ram_select=0.
- Reset mid-operation: abandons request, no done pulse; ram_write/ram_select low from the first reset cycle. A write already in WR when reset asserts is complete for that cycle only.

## Structure
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, misalign-check function.
- Sub-module mem_lane_align (combinational): store merge (old word, wdata, size, offset -> new word) and load extract (word, size, offset, lsigned -> rdata). Controller holds FSM and registers only.

## Test plan
- Word store 0xDEADBEEF to addr 0x0010 then word load 0x0010 -> RAM word 4 = 0xDEADBEEF; store done at T+2; load rdata=0xDEADBEEF at T+2.
- Word 4 = 0x11223344; byte store 0xAB to addr 0x0011 -> RD then WR; RAM word 4 = 0x1122AB44; done at T+3.
- Word 4 = 0x8000F0FF; signed byte load addr 0x0010 -> 0xFFFFFFFF; unsigned half load addr 0x0012 -> 0x00008000; signed half load 0x0012 -> 0xFFFF8000.
- Half load addr 0x0013 and word store addr 0x0012 -> done+err at T+1, ram_select never asserted, RAM unchanged; size=11 likewise.
- req held high continuously -> accepts only in IDLE; ready low through RD/WR/FIN; exactly one done per accepted request.
- Reset asserted during WR of a sub-word store -> next edge all outputs at reset values, no done, ready=1 after reset release.
